// File: rtl/pixie_raster_gen.sv
// Pixie raster generator: raster timing, 1-bpp frame-buffer fetch and
// MSB-first pixel serialiser, all advancing on the pixel clock-enable.
module pixie_raster_gen #(
    parameter int unsigned H_TOTAL   = 112,
    parameter int unsigned H_ACTIVE  = 64,
    parameter int unsigned HS_START  = 82,
    parameter int unsigned HS_WIDTH  = 12,
    parameter int unsigned V_TOTAL   = 262,
    parameter int unsigned V_ACTIVE  = 128,
    parameter int unsigned VS_START  = 182,
    parameter int unsigned VS_HEIGHT = 16,
    parameter int unsigned V_REPEAT  = 1,
    parameter int unsigned FB_AW     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic             disp_on,
    output logic             fb_read_en,
    output logic [FB_AW-1:0] fb_addr,
    input  logic [7:0]       fb_data,
    output logic             video,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             csync,
    output logic             hblank,
    output logic             vblank,
    output logic             frame_start
);

    localparam int unsigned HW   = $clog2(H_TOTAL);
    localparam int unsigned VW   = $clog2(V_TOTAL);
    localparam int unsigned RW   = (V_REPEAT > 1) ? $clog2(V_REPEAT) : 1;
    localparam int unsigned COLB = $clog2(H_ACTIVE / 8);

    // Counter state; primed is 0 until the first tick after reset so that tick lands on h=0, v=0
    logic [HW-1:0]    h, h_nx;
    logic [VW-1:0]    v, v_nx;
    logic [RW-1:0]    rep, rep_nx;
    logic [VW-1:0]    row, row_nx;
    logic             primed;
    logic             disp_latched;
    logic [7:0]       shreg;

    // Derived next-tick values
    logic             fs_nx;
    logic             disp_nx;
    logic [HW-1:0]    hd_nx;
    logic [VW-1:0]    vd_nx;
    logic             act_h_nx;
    logic             act_v_nx;
    logic             hs_nx;
    logic             vs_nx;
    logic             rd_nx;
    logic [FB_AW-1:0] fb_addr_nx;
    logic             load;
    logic [7:0]       shreg_nx;

    // Next raster position: h wraps into v, v carries rep, rep wrap advances row
    always_comb begin
        h_nx   = h;
        v_nx   = v;
        rep_nx = rep;
        row_nx = row;
        if (!primed) begin
            h_nx   = '0;
            v_nx   = '0;
            rep_nx = '0;
            row_nx = '0;
        end else if (h == HW'(H_TOTAL - 1)) begin
            h_nx = '0;
            if (v == VW'(V_TOTAL - 1)) begin
                v_nx   = '0;
                rep_nx = '0;
                row_nx = '0;
            end else begin
                v_nx = v + VW'(1);
                if (rep == RW'(V_REPEAT - 1)) begin
                    rep_nx = '0;
                    row_nx = row + VW'(1);
                end else begin
                    rep_nx = rep + RW'(1);
                end
            end
        end else begin
            h_nx = h + HW'(1);
        end
    end

    // Fetch, shifter and timing decode for the upcoming tick; timing uses the position two ticks back
    always_comb begin
        fs_nx   = (h_nx == '0) && (v_nx == '0);
        disp_nx = fs_nx ? disp_on : disp_latched;

        if (h_nx >= HW'(2)) begin
            hd_nx = h_nx - HW'(2);
            vd_nx = v_nx;
        end else begin
            hd_nx = h_nx + HW'(H_TOTAL - 2);
            vd_nx = (v_nx == '0) ? VW'(V_TOTAL - 1) : v_nx - VW'(1);
        end

        act_h_nx = 32'(hd_nx) < H_ACTIVE;
        act_v_nx = 32'(vd_nx) < V_ACTIVE;
        hs_nx    = (32'(hd_nx) >= HS_START) && (32'(hd_nx) < HS_START + HS_WIDTH);
        vs_nx    = (32'(vd_nx) >= VS_START) && (32'(vd_nx) < VS_START + VS_HEIGHT);

        rd_nx      = (h_nx[2:0] == 3'd0) && (32'(h_nx) < H_ACTIVE) &&
                     (32'(v_nx) < V_ACTIVE) && disp_nx;
        fb_addr_nx = FB_AW'((32'(row_nx) << COLB) | 32'(h_nx >> 3));

        load     = primed && (h[2:0] == 3'd1) && (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
        shreg_nx = load ? fb_data : {shreg[6:0], 1'b0};
    end

    // State and registered outputs; only fb_read_en moves on clocks without ce_pix
    always_ff @(posedge clk) begin
        if (reset) begin
            h            <= '0;
            v            <= '0;
            rep          <= '0;
            row          <= '0;
            primed       <= 1'b0;
            disp_latched <= 1'b0;
            shreg        <= '0;
            fb_read_en   <= 1'b0;
            fb_addr      <= '0;
            video        <= 1'b0;
            de           <= 1'b0;
            hsync        <= 1'b0;
            vsync        <= 1'b0;
            csync        <= 1'b0;
            hblank       <= 1'b0;
            vblank       <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            fb_read_en <= 1'b0;
            if (ce_pix) begin
                h            <= h_nx;
                v            <= v_nx;
                rep          <= rep_nx;
                row          <= row_nx;
                primed       <= 1'b1;
                disp_latched <= disp_nx;
                shreg        <= shreg_nx;
                fb_read_en   <= rd_nx;
                if (rd_nx) begin
                    fb_addr <= fb_addr_nx;
                end
                video       <= shreg_nx[7] & act_h_nx & act_v_nx & disp_nx;
                de          <= act_h_nx & act_v_nx;
                hsync       <= hs_nx;
                vsync       <= vs_nx;
                csync       <= hs_nx ^ vs_nx;
                hblank      <= ~act_h_nx;
                vblank      <= ~act_v_nx;
                frame_start <= fs_nx;
            end
        end
    end

endmodule

// File: tb/tb_pixie_raster_gen.sv
// Bench for pixie_raster_gen: default-geometry instance plus a small V_REPEAT=2 instance,
// both checked every clock against a frame-arithmetic reference model.
module tb_pixie_raster_gen;

    localparam int F0 = 112 * 262;
    localparam int F1 = 40 * 30;

    typedef struct packed {
        logic       video;
        logic       de;
        logic       hsync;
        logic       vsync;
        logic       csync;
        logic       hblank;
        logic       vblank;
        logic       frame_start;
        logic       rd;
        logic [9:0] addr;
    } exp_t;

    logic       clk;
    logic       rst0, ce0, don0;
    logic       rst1, ce1, don1;
    logic       fb_read_en0, fb_read_en1;
    logic [9:0] fb_addr0, fb_addr1;
    logic [7:0] fbd0, fbd1;
    logic       video0, de0, hsync0, vsync0, csync0, hblank0, vblank0, frame_start0;
    logic       video1, de1, hsync1, vsync1, csync1, hblank1, vblank1, frame_start1;

    logic [7:0] mem0 [1024];
    logic [7:0] mem1 [1024];

    int  checks = 0;
    int  errors = 0;
    int  tk0 = -1, tk1 = -1;
    bit  dm0 = 1'b0, dm1 = 1'b0;
    bit  ce0e = 1'b0, ce1e = 1'b0;

    pixie_raster_gen u0 (
        .clk(clk), .reset(rst0), .ce_pix(ce0), .disp_on(don0),
        .fb_read_en(fb_read_en0), .fb_addr(fb_addr0), .fb_data(fbd0),
        .video(video0), .de(de0), .hsync(hsync0), .vsync(vsync0), .csync(csync0),
        .hblank(hblank0), .vblank(vblank0), .frame_start(frame_start0)
    );

    pixie_raster_gen #(
        .H_TOTAL(40), .H_ACTIVE(16), .HS_START(20), .HS_WIDTH(6),
        .V_TOTAL(30), .V_ACTIVE(16), .VS_START(20), .VS_HEIGHT(3),
        .V_REPEAT(2), .FB_AW(10)
    ) u1 (
        .clk(clk), .reset(rst1), .ce_pix(ce1), .disp_on(don1),
        .fb_read_en(fb_read_en1), .fb_addr(fb_addr1), .fb_data(fbd1),
        .video(video1), .de(de1), .hsync(hsync1), .vsync(vsync1), .csync(csync1),
        .hblank(hblank1), .vblank(vblank1), .frame_start(frame_start1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read frame buffers
    always @(posedge clk) begin
        if (fb_read_en0) fbd0 <= mem0[fb_addr0];
        if (fb_read_en1) fbd1 <= mem1[fb_addr1];
    end

    // Expected outputs during tick tk of a raster restarted at reset
    function automatic exp_t model(input bit sel1, input int tk, input bit disp, input bit ceedge);
        int ht, ha, hs, hsw, vt, va, vs, vsh, rep, fr, p, hh, vv, d, hd, vd, a;
        logic [7:0] b;
        exp_t e;
        e = '0;
        if (sel1) begin
            ht = 40;  ha = 16; hs = 20; hsw = 6;  vt = 30;  va = 16;  vs = 20;  vsh = 3;  rep = 2;
        end else begin
            ht = 112; ha = 64; hs = 82; hsw = 12; vt = 262; va = 128; vs = 182; vsh = 16; rep = 1;
        end
        if (tk < 0) return e;
        fr = ht * vt;
        p  = tk % fr;
        hh = p % ht;
        vv = p / ht;
        d  = (p + fr - 2) % fr;
        hd = d % ht;
        vd = d / ht;
        e.de          = (hd < ha) && (vd < va);
        e.hsync       = (hd >= hs) && (hd < hs + hsw);
        e.vsync       = (vd >= vs) && (vd < vs + vsh);
        e.csync       = e.hsync ^ e.vsync;
        e.hblank      = !(hd < ha);
        e.vblank      = !(vd < va);
        e.frame_start = (p == 0);
        if (e.de && disp) begin
            a = ((vd / rep) * (ha / 8) + hd / 8) % 1024;
            b = sel1 ? mem1[10'(a)] : mem0[10'(a)];
            b = b >> (7 - hd % 8);
            e.video = b[0];
        end
        e.rd = ceedge && disp && (hh % 8 == 0) && (hh < ha) && (vv < va);
        if (e.rd) e.addr = 10'(((vv / rep) * (ha / 8) + hh / 8) % 1024);
        return e;
    endfunction

    function automatic exp_t obs(input bit sel1, input bit with_addr);
        exp_t o;
        if (sel1)
            o = {video1, de1, hsync1, vsync1, csync1, hblank1, vblank1, frame_start1,
                 fb_read_en1, with_addr ? fb_addr1 : 10'd0};
        else
            o = {video0, de0, hsync0, vsync0, csync0, hblank0, vblank0, frame_start0,
                 fb_read_en0, with_addr ? fb_addr0 : 10'd0};
        return o;
    endfunction

    // One clock: advance the tick bookkeeping with what the DUTs sampled, then settle
    task automatic step();
        @(posedge clk);
        ce0e = 1'b0;
        ce1e = 1'b0;
        if (rst0) tk0 = -1;
        else if (ce0) begin
            tk0++;
            ce0e = 1'b1;
            if (tk0 % F0 == 0) dm0 = don0;
        end
        if (rst1) tk1 = -1;
        else if (ce1) begin
            tk1++;
            ce1e = 1'b1;
            if (tk1 % F1 == 0) dm1 = don1;
        end
        #1;
    endtask

    task automatic test_reset();
        exp_t o;
        rst0 = 1'b1; rst1 = 1'b1; ce0 = 1'b1; ce1 = 1'b1; don0 = 1'b1; don1 = 1'b1;
        repeat (3) step();
        o = obs(0, 1'b1);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_u0 got=%h exp=0", o); end
        o = obs(1, 1'b1);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_u1 got=%h exp=0", o); end
    endtask

    task automatic test_active_frame();
        exp_t e, o;
        int bad = 0, de_cnt = 0, hs_cnt = 0, hs_first = -1;
        rst0 = 1'b0;
        while (tk0 < 90 * 112 + 37) begin
            step();
            e = model(0, tk0, dm0, ce0e);
            o = obs(0, e.rd);
            if (bad < 5) begin
                checks++;
                if (o !== e) begin
                    errors++; bad++;
                    $display("FAIL active_frame tk=%0d got=%h exp=%h", tk0, o, e);
                end
            end
            if (tk0 >= 5 * 112 + 2 && tk0 < 6 * 112 + 2) begin
                if (de0) de_cnt++;
                if (hsync0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = tk0 - 5 * 112;
                end
            end
        end
        checks++;
        if (de_cnt != 64) begin errors++; $display("FAIL de_per_line got=%0d exp=64", de_cnt); end
        checks++;
        if (hs_cnt != 12) begin errors++; $display("FAIL hsync_width got=%0d exp=12", hs_cnt); end
        checks++;
        if (hs_first != 84) begin errors++; $display("FAIL hsync_offset got=%0d exp=84", hs_first); end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        rst0 = 1'b1;
        step();
        o = obs(0, 1'b1);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_mid_zero got=%h exp=0", o); end
        step();
        rst0 = 1'b0;
        step();
        checks++;
        if (frame_start0 !== 1'b1 || fb_read_en0 !== 1'b1 || fb_addr0 !== 10'd0) begin
            errors++;
            $display("FAIL reset_first_tick got fs=%b rd=%b addr=%0d exp fs=1 rd=1 addr=0",
                     frame_start0, fb_read_en0, fb_addr0);
        end
        e = model(0, tk0, dm0, ce0e);
        o = obs(0, e.rd);
        checks++;
        if (o !== e) begin errors++; $display("FAIL reset_first_model got=%h exp=%h", o, e); end
    endtask

    task automatic test_disp_off();
        exp_t e, o;
        int bad = 0, rd_cnt = 0, fs_cnt = 0, fs_at = -1;
        while (tk0 < F0) begin
            step();
            if (tk0 == 50 * 112) don0 = 1'b0;
            e = model(0, tk0, dm0, ce0e);
            o = obs(0, e.rd);
            if (bad < 5) begin
                checks++;
                if (o !== e) begin
                    errors++; bad++;
                    $display("FAIL disp_frame tk=%0d got=%h exp=%h", tk0, o, e);
                end
            end
            if (fb_read_en0) rd_cnt++;
            if (frame_start0) begin fs_cnt++; fs_at = tk0; end
        end
        checks++;
        if (rd_cnt != 1023) begin errors++; $display("FAIL frame_reads got=%0d exp=1023", rd_cnt); end
        checks++;
        if (fs_cnt != 1 || fs_at != F0) begin
            errors++;
            $display("FAIL frame_period got cnt=%0d at=%0d exp cnt=1 at=%0d", fs_cnt, fs_at, F0);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        int bad = 0, rd_cnt = 0, vid_cnt = 0, cs_bad = 0;
        while (tk0 < F0 + 140 * 112) begin
            step();
            e = model(0, tk0, dm0, ce0e);
            o = obs(0, e.rd);
            if (bad < 5) begin
                checks++;
                if (o !== e) begin
                    errors++; bad++;
                    $display("FAIL dark_frame tk=%0d got=%h exp=%h", tk0, o, e);
                end
            end
            if (cs_bad < 5) begin
                checks++;
                if (csync0 !== (hsync0 ^ vsync0)) begin
                    errors++; cs_bad++;
                    $display("FAIL csync tk=%0d got=%b exp=%b", tk0, csync0, hsync0 ^ vsync0);
                end
            end
            if (fb_read_en0) rd_cnt++;
            if (video0) vid_cnt++;
        end
        checks++;
        if (rd_cnt != 0) begin errors++; $display("FAIL dark_reads got=%0d exp=0", rd_cnt); end
        checks++;
        if (vid_cnt != 0) begin errors++; $display("FAIL dark_video got=%0d exp=0", vid_cnt); end
    endtask

    task automatic test_ce_cadence();
        exp_t e, o;
        int bad = 0, rd_cnt = 0, dbl = 0, na = 0;
        int addrs [8];
        int want [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
        bit prev_rd = 1'b0;
        rst0 = 1'b1;
        rst1 = 1'b0;
        for (int n = 0; n < 3 * (F1 + F1 / 2); n++) begin
            ce1 = (n % 3 == 0);
            step();
            e = model(1, tk1, dm1, ce1e);
            o = obs(1, e.rd);
            if (bad < 5) begin
                checks++;
                if (o !== e) begin
                    errors++; bad++;
                    $display("FAIL cadence tk=%0d got=%h exp=%h", tk1, o, e);
                end
            end
            if (fb_read_en1 && prev_rd) dbl++;
            prev_rd = fb_read_en1;
            if (fb_read_en1 && tk1 < F1) begin
                rd_cnt++;
                if (na < 8) begin addrs[na] = int'(fb_addr1); na++; end
            end
        end
        checks++;
        if (dbl != 0) begin errors++; $display("FAIL read_pulse_len got=%0d long pulses exp=0", dbl); end
        checks++;
        if (rd_cnt != 32) begin errors++; $display("FAIL repeat_reads got=%0d exp=32", rd_cnt); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= na || addrs[i] != want[i]) begin
                errors++;
                $display("FAIL addr_sweep idx=%0d got=%0d exp=%0d", i, (i < na) ? addrs[i] : -1, want[i]);
            end
        end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; ce0 = 1'b0; ce1 = 1'b0; don0 = 1'b0; don1 = 1'b0;
        fbd0 = '0; fbd1 = '0;
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 8'($urandom);
            mem1[i] = 8'(i);
        end
        test_reset();
        test_active_frame();
        test_reset_mid();
        test_disp_off();
        test_back_to_back();
        test_ce_cadence();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixie_raster_gen.md
Name: pixie_raster_gen

Overview:
- Parametrised successor to the fixed 64x128 Pixie display back end. Generates raster timing (hsync, vsync, csync, blanking, data-enable) and fetches 1-bpp bytes from the dual-port frame buffer. Serialises those bytes MSB-first to a mono video output.
- Adds pixel clock-enable, row repeat (e.g. 64x32 Studio II mode displayed as 128 lines), display on/off latched per frame, separate sync/blank outputs, and a frame-start pulse.
- Sits between the frame-buffer read port and the MiSTer video mixer.

Parameters:
- H_TOTAL, 112, ticks per line
- H_ACTIVE, 64, active pixels per line; multiple of 8, and H_ACTIVE/8 is a power of 2
- HS_START, 82, first hsync tick (counter value)
- HS_WIDTH, 12, hsync length in ticks
- V_TOTAL, 262, lines per frame
- V_ACTIVE, 128, active lines
- VS_START, 182, first vsync line
- VS_HEIGHT, 16, vsync length in lines
- V_REPEAT, 1, output lines per frame-buffer row (1, 2 or 4)
- FB_AW, 10, frame-buffer address width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ce_pix  in  1  pixel tick enable; all state advances only when 1
- disp_on  in  1  display enable request
- fb_read_en  out  1  frame-buffer read strobe
- fb_addr  out  FB_AW  byte address: {row, byte_col}
- fb_data  in  8  read data, valid one clk after fb_read_en and held until the next read
- video  out  1  pixel out
- de  out  1  active_h & active_v, pipeline-aligned with video
- hsync  out  1  active-high
- vsync  out  1  active-high
- csync  out  1  hsync ^ vsync
- hblank  out  1  ~active_h
- vblank  out  1  ~active_v
- frame_start  out  1  one-tick pulse at h=0, v=0

Behaviour:
- Counters
  - h in 0..H_TOTAL-1 increments on each ce_pix and wraps to 0.
  - v increments when h wraps, and wraps to 0 after V_TOTAL-1.
  - rep counter in 0..V_REPEAT-1 increments with v and clears at v wrap.
  - row increments when rep wraps; row clears at v wrap.
- Fetch
  - fb_read_en=1 for exactly one clk on the tick where h[2:0]=0, h<H_ACTIVE, v<V_ACTIVE and disp_latched=1.
  - fb_addr = {row, h/8}, truncated to FB_AW. Stable while fb_read_en=1.
- Shifter
  - On the tick with h[2:0]=1 inside the active region, load fb_data.
  - On every other tick, shift left, filling with 0.
  - video = shreg[7] & de_pipe & disp_latched, registered.
- Latency and alignment
  - Active column c (0..H_ACTIVE-1) appears on video/de during the tick where h = c+2.
  - hsync and hblank are computed on the same 2-tick-delayed h: hsync=1 for h-2 in [HS_START, HS_START+HS_WIDTH).
  - vsync=1 for v in [VS_START, VS_START+VS_HEIGHT). vsync/vblank update together with the delayed line boundary.
  - Constraints: H_TOTAL ≥ H_ACTIVE+2 and HS_START+HS_WIDTH ≤ H_TOTAL.
- Display enable
  - disp_on is sampled into disp_latched only at frame_start, so a frame is never torn.
  - When disp_latched=0: sync/blank/de continue normally, fb_read_en=0, video=0.
- ce_pix low: all outputs hold their values; fb_read_en is forced low after its one-clk pulse.
- Reset (any cycle, including mid-line or mid-fetch):
  - h, v, rep, row and shreg clear to 0; disp_latched=0.
  - All outputs = 0 except hblank=0 and vblank=0 (de=0 until the pipeline fills).
  - First tick after reset is h=0, v=0 with frame_start=1.
- Wrap
  - Line 0 follows line V_TOTAL-1 with no gap.
  - Pixels shifted past column H_ACTIVE-1 are 0 (the shifter is not reloaded outside the active region).

Test Plan:
- Defaults, ce_pix=1, disp_on=1, fb_data=0xA5 on every read → each active line shows 1,0,1,0,0,1,0,1 repeated ×8; 64 de ticks per line; hsync high for 12 ticks starting 84 ticks after h=0; 128 de lines per 262-line frame; vsync on lines 182..197.
- Address sweep: RAM model with data = address[7:0], V_REPEAT=2, V_ACTIVE=128 → fb_addr row runs 0..63, each row fetched on 2 consecutive lines; bytes 0..7 per line.
- disp_on toggled 1→0 at v=50 → video remains valid until the end of the frame; the next frame has video=0 and no fb_read_en; sync is unchanged.
- ce_pix=1 every 3rd clk → identical pixel sequence and sync counts in ticks; each fb_read_en pulse lasts 1 clk.
- Reset asserted at h=37, v=90 mid-fetch → outputs 0 next clk; after release frame_start=1 and the first fb_addr=0.
- Back-to-back frames → frame_start once every H_TOTAL*V_TOTAL = 29344 ticks; csync = hsync XOR vsync on every tick.
